// File: rtl/memory_stage.sv
// ----------------------------------------------------------------------------
// memory_stage
//   Y86-64 pipeline memory stage: byte-addressed little-endian data memory
//   with a combinational 8-byte read port, a clocked 8-byte write port and
//   the W pipeline register that feeds writeback.
//
// Parameters
//   MEM_BYTES  data-memory size in bytes (multiple of 8)
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset (W only)
//   M_stat, M_icode       status / icode of the instruction in M
//   M_valE, M_valA        ALU result / register operand from the M register
//   M_dstE, M_dstM        destination register IDs (0xF = none)
//   W_stall, W_bubble     W-register hold / NOP-insert from the hazard unit
//   m_stat, m_valM        combinational status and read data of M
//   W_stat .. W_dstM      registered writeback-stage fields
// ----------------------------------------------------------------------------
module memory_stage #(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  M_stat,
   input  logic [3:0]  M_icode,
   input  logic [63:0] M_valE,
   input  logic [63:0] M_valA,
   input  logic [3:0]  M_dstE,
   input  logic [3:0]  M_dstM,
   input  logic        W_stall,
   input  logic        W_bubble,
   output logic [1:0]  m_stat,
   output logic [63:0] m_valM,
   output logic [1:0]  W_stat,
   output logic [3:0]  W_icode,
   output logic [63:0] W_valE,
   output logic [63:0] W_valM,
   output logic [3:0]  W_dstE,
   output logic [3:0]  W_dstM
);

   localparam int unsigned AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
   localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

   typedef enum logic [1:0] {
      STAT_AOK = 2'b00,
      STAT_HLT = 2'b01,
      STAT_ADR = 2'b10,
      STAT_INS = 2'b11
   } stat_t;

   typedef enum logic [3:0] {
      IC_NOP    = 4'h1,
      IC_RMMOVQ = 4'h4,
      IC_MRMOVQ = 4'h5,
      IC_CALL   = 4'h8,
      IC_RET    = 4'h9,
      IC_PUSHQ  = 4'hA,
      IC_POPQ   = 4'hB
   } icode_t;

   localparam logic [3:0] REG_NONE = 4'hF;

   // Data memory is deliberately never reset: contents survive rst_n.
   logic [7:0]    mem [MEM_BYTES];

   logic          mem_rd;
   logic          mem_wr;
   logic [63:0]   addr;
   logic          dmem_error;
   logic          mem_we;
   logic [AW-1:0] base;

   always_comb begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      addr   = M_valE;
      case (M_icode)
         IC_RMMOVQ, IC_CALL, IC_PUSHQ: mem_wr = 1'b1;
         IC_MRMOVQ:                    mem_rd = 1'b1;
         IC_RET, IC_POPQ: begin
            mem_rd = 1'b1;
            addr   = M_valA;
         end
         default: ;
      endcase
   end

   // Full 64-bit compare: any address whose 8-byte window leaves memory faults.
   assign dmem_error = (mem_rd | mem_wr) && (addr > LAST_ADDR);
   // Index only meaningful when no error; then addr+7 always fits in memory.
   assign base       = addr[AW-1:0];

   always_comb begin
      m_valM = '0;
      if (mem_rd && !dmem_error) begin
         for (int unsigned k = 0; k < 8; k++) begin
            m_valM[8*k +: 8] = mem[base + AW'(k)];
         end
      end
   end

   assign m_stat = dmem_error ? STAT_ADR : M_stat;

   assign mem_we = mem_wr && (M_stat == STAT_AOK) && !dmem_error && !W_stall && rst_n;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned k = 0; k < 8; k++) begin
            mem[base + AW'(k)] <= M_valA[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         W_stat  <= STAT_AOK;
         W_icode <= IC_NOP;
         W_valE  <= '0;
         W_valM  <= '0;
         W_dstE  <= REG_NONE;
         W_dstM  <= REG_NONE;
      end else if (W_stall) begin
         W_stat  <= W_stat;
         W_icode <= W_icode;
         W_valE  <= W_valE;
         W_valM  <= W_valM;
         W_dstE  <= W_dstE;
         W_dstM  <= W_dstM;
      end else if (W_bubble) begin
         W_stat  <= STAT_AOK;
         W_icode <= IC_NOP;
         W_valE  <= '0;
         W_valM  <= '0;
         W_dstE  <= REG_NONE;
         W_dstM  <= REG_NONE;
      end else begin
         W_stat  <= m_stat;
         W_icode <= M_icode;
         W_valE  <= M_valE;
         W_valM  <= m_valM;
         W_dstE  <= M_dstE;
         W_dstM  <= M_dstM;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// ----------------------------------------------------------------------------
// tb_memory_stage
//   Self-checking bench for memory_stage: directed scenarios followed by a
//   randomized run, all compared against a byte-array reference model.
// ----------------------------------------------------------------------------
module tb_memory_stage;

   localparam int unsigned MB = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  M_stat;
   logic [3:0]  M_icode;
   logic [63:0] M_valE, M_valA;
   logic [3:0]  M_dstE, M_dstM;
   logic        W_stall, W_bubble;
   logic [1:0]  m_stat;
   logic [63:0] m_valM;
   logic [1:0]  W_stat;
   logic [3:0]  W_icode;
   logic [63:0] W_valE, W_valM;
   logic [3:0]  W_dstE, W_dstM;

   memory_stage #(.MEM_BYTES(MB)) dut (
      .clk(clk), .rst_n(rst_n),
      .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE), .M_valA(M_valA),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall), .W_bubble(W_bubble),
      .m_stat(m_stat), .m_valM(m_valM),
      .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
      .W_dstE(W_dstE), .W_dstM(W_dstM)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   // reference model state
   logic [7:0]  ref_mem [MB];
   logic [1:0]  r_stat;
   logic [3:0]  r_icode;
   logic [63:0] r_valE, r_valM;
   logic [3:0]  r_dstE, r_dstM;
   // per-cycle expectations computed before the clock edge
   logic        e_wr, e_err;
   logic [63:0] e_addr, e_valM;
   logic [1:0]  e_stat;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rd_word(input logic [63:0] a);
      logic [63:0] v;
      int unsigned b;
      v = '0;
      b = a[31:0];
      for (int k = 0; k < 8; k++) v = v | (64'(ref_mem[b + k]) << (8 * k));
      return v;
   endfunction

   task automatic model_bubble();
      r_stat = 2'b00; r_icode = 4'h1; r_valE = '0; r_valM = '0; r_dstE = 4'hF; r_dstM = 4'hF;
   endtask

   task automatic chk_w(input string tag);
      chk({tag, "_W_stat"},  W_stat,  r_stat);
      chk({tag, "_W_icode"}, W_icode, r_icode);
      chk({tag, "_W_valE"},  W_valE,  r_valE);
      chk({tag, "_W_valM"},  W_valM,  r_valM);
      chk({tag, "_W_dstE"},  W_dstE,  r_dstE);
      chk({tag, "_W_dstM"},  W_dstM,  r_dstM);
   endtask

   task automatic set_in(input logic [1:0] st, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                         input logic stl, input logic bub);
      M_stat = st; M_icode = ic; M_valE = ve; M_valA = va;
      M_dstE = de; M_dstM = dm; W_stall = stl; W_bubble = bub;
   endtask

   // Let combinational outputs settle, derive expectations from the rules, check them.
   task automatic settle();
      logic rd;
      #1;
      rd     = (M_icode == 4'h5) || (M_icode == 4'h9) || (M_icode == 4'hB);
      e_wr   = (M_icode == 4'h4) || (M_icode == 4'h8) || (M_icode == 4'hA);
      e_addr = ((M_icode == 4'h9) || (M_icode == 4'hB)) ? M_valA : M_valE;
      e_err  = (rd || e_wr) && (e_addr > 64'(MB - 8));
      e_stat = e_err ? 2'b10 : M_stat;
      e_valM = (rd && !e_err) ? rd_word(e_addr) : 64'd0;
      chk("m_stat", m_stat, e_stat);
      chk("m_valM", m_valM, e_valM);
   endtask

   // Clock edge: update the model as the edge would, then check W one step later.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         model_bubble();
      end else begin
         if (e_wr && M_stat == 2'b00 && !e_err && !W_stall)
            for (int k = 0; k < 8; k++) ref_mem[e_addr[31:0] + k] = M_valA[8*k +: 8];
         if (W_stall) begin
            // hold
         end else if (W_bubble) begin
            model_bubble();
         end else begin
            r_stat = e_stat; r_icode = M_icode; r_valE = M_valE;
            r_valM = e_valM; r_dstE = M_dstE; r_dstM = M_dstM;
         end
      end
      #1;
      chk_w("tick");
   endtask

   task automatic step(input logic [1:0] st, input logic [3:0] ic, input logic [63:0] ve,
                       input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                       input logic stl, input logic bub);
      set_in(st, ic, ve, va, de, dm, stl, bub);
      settle();
      tick();
   endtask

   function automatic logic [63:0] rnd_addr();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 7)       return 64'($urandom_range(0, MB - 8));
      else if (r == 7) return 64'(MB - 8 + $urandom_range(0, 8));
      else if (r == 8) return {$urandom, $urandom};
      else             return 64'($urandom_range(0, MB - 1));
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] saved, d;
      rst_n = 1'b0;
      set_in(2'b00, 4'h1, '0, '0, 4'hF, 4'hF, 1'b0, 1'b0);
      model_bubble();
      #12;
      chk_w("reset");
      #1 rst_n = 1'b1;

      // fill memory so every later read has a known value
      for (int unsigned a = 0; a < MB; a += 8)
         step(2'b00, 4'h4, 64'(a), {$urandom, $urandom}, 4'hF, 4'hF, 1'b0, 1'b0);

      // store then load at 0x10
      step(2'b00, 4'h4, 64'h10, 64'h1122334455667788, 4'hF, 4'hF, 1'b0, 1'b0);
      set_in(2'b00, 4'h5, 64'h10, 64'h0, 4'hF, 4'h3, 1'b0, 1'b0);
      settle();
      chk("r28_valM", m_valM, 64'h1122334455667788);
      chk("r28_byte10", m_valM[7:0], 8'h88);
      tick();
      chk("r28_W_valM", W_valM, 64'h1122334455667788);

      // address boundary
      set_in(2'b00, 4'h5, 64'(MB - 7), 64'h0, 4'hF, 4'h3, 1'b0, 1'b0);
      settle();
      chk("r29_stat_hi", m_stat, 2'b10);
      chk("r29_valM_hi", m_valM, 64'h0);
      tick();
      chk("r29_W_stat", W_stat, 2'b10);
      set_in(2'b00, 4'h5, 64'(MB - 8), 64'h0, 4'hF, 4'h3, 1'b0, 1'b0);
      settle();
      chk("r29_stat_ok", m_stat, 2'b00);
      tick();
      step(2'b00, 4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 64'h55, 4'hF, 4'hF, 1'b0, 1'b0);

      // pushq with non-AOK status must not write; valid push then pop
      saved = rd_word(64'h100);
      step(2'b01, 4'hA, 64'h100, 64'h5, 4'h4, 4'hF, 1'b0, 1'b0);
      set_in(2'b00, 4'h5, 64'h100, 64'h0, 4'hF, 4'h2, 1'b0, 1'b0);
      settle();
      chk("r30_nowrite", m_valM, saved);
      tick();
      step(2'b00, 4'hA, 64'h100, 64'hABCD, 4'h4, 4'hF, 1'b0, 1'b0);
      set_in(2'b00, 4'hB, 64'h108, 64'h100, 4'h4, 4'h2, 1'b0, 1'b0);
      settle();
      chk("r30_pop", m_valM, 64'hABCD);
      tick();

      // stall holds W and suppresses the write; bubble loads a nop
      step(2'b00, 4'h5, 64'h18, 64'h0, 4'hF, 4'h3, 1'b0, 1'b0);
      saved = rd_word(64'h20);
      step(2'b00, 4'h4, 64'h20, 64'hDEAD_BEEF, 4'hF, 4'hF, 1'b1, 1'b0);
      chk("r31_hold_icode", W_icode, 4'h5);
      chk("r31_hold_dstM", W_dstM, 4'h3);
      set_in(2'b00, 4'h5, 64'h20, 64'h0, 4'hF, 4'h3, 1'b0, 1'b0);
      settle();
      chk("r31_mem20", m_valM, saved);
      tick();
      step(2'b00, 4'h4, 64'h20, 64'h77, 4'hF, 4'hF, 1'b1, 1'b1);
      chk("r31_both_icode", W_icode, 4'h5);
      step(2'b00, 4'h5, 64'h20, 64'h0, 4'hF, 4'h3, 1'b0, 1'b1);
      chk("r31_bub_icode", W_icode, 4'h1);
      chk("r31_bub_dstE", W_dstE, 4'hF);
      chk("r31_bub_dstM", W_dstM, 4'hF);
      chk("r31_bub_stat", W_stat, 2'b00);

      // back-to-back write and read at 0x40
      saved = rd_word(64'h40);
      set_in(2'b00, 4'h5, 64'h40, 64'h0, 4'hF, 4'h1, 1'b0, 1'b0);
      settle();
      chk("r33_old", m_valM, saved);
      tick();
      d = ~saved;
      step(2'b00, 4'h4, 64'h40, d, 4'hF, 4'hF, 1'b0, 1'b0);
      set_in(2'b00, 4'h5, 64'h40, 64'h0, 4'hF, 4'h1, 1'b0, 1'b0);
      settle();
      chk("r33_new", m_valM, d);
      tick();

      // asynchronous reset mid-cycle; no write while held; memory retained
      step(2'b00, 4'h5, 64'h40, 64'h0, 4'hF, 4'h3, 1'b0, 1'b0);
      chk("r32_pre_icode", W_icode, 4'h5);
      #2 rst_n = 1'b0;
      #1;
      chk("r32_async_icode", W_icode, 4'h1);
      chk("r32_async_dstM", W_dstM, 4'hF);
      model_bubble();
      chk_w("r32_async");
      set_in(2'b00, 4'h4, 64'h40, 64'h1234, 4'hF, 4'hF, 1'b0, 1'b0);
      settle();
      tick();
      #3 rst_n = 1'b1;
      set_in(2'b00, 4'h5, 64'h40, 64'h0, 4'hF, 4'h3, 1'b0, 1'b0);
      settle();
      chk("r32_retained", m_valM, d);
      tick();
      chk("r27_first_edge", W_icode, 4'h5);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
              4'($urandom), rnd_addr(), ($urandom_range(0, 1) == 0) ? rnd_addr() : {$urandom, $urandom},
              4'($urandom), 4'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter: MEM_BYTES, default 1024, data-memory size in bytes, multiple of 8.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 M_stat  input  2  status of instruction in M: 00 AOK, 01 HLT, 10 ADR, 11 INS.
REQ-005 M_icode  input  4  Y86-64 icode of instruction in M.
REQ-006 M_valE, M_valA  input  64 each  ALU result and register operand from M register.
REQ-007 M_dstE, M_dstM  input  4 each  destination register IDs; 0xF = none.
REQ-008 W_stall, W_bubble  input  1 each  W-register hold / NOP-insert controls from hazard unit.
REQ-009 m_stat  output  2  combinational status of M instruction after memory access.
REQ-010 m_valM  output  64  combinational data read from memory.
REQ-011 W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM  output  2/4/64/64/4/4  registered writeback-stage fields.

Function
REQ-012 Memory address = M_valE for icodes 4 (rmmovq), 5 (mrmovq), 8 (call), A (pushq); M_valA for 9 (ret), B (popq); don't-care otherwise.
REQ-013 Read access for icodes 5, 9, B; write access for icodes 4, 8, A; no access for all others.
REQ-014 Memory is byte-addressed, little-endian; each access covers 8 consecutive bytes addr..addr+7; no alignment requirement.
REQ-015 dmem_error asserted when a read or write access has addr > MEM_BYTES-8, unsigned 64-bit compare; no-access icodes never raise it.
REQ-016 m_valM = 8-byte little-endian word at addr on read access without dmem_error; 0 otherwise; read is combinational, same cycle.
REQ-017 m_stat = 10 (ADR) when dmem_error; otherwise m_stat = M_stat.
REQ-018 Write of M_valA to addr occurs at rising clk only when write access, M_stat = 00, no dmem_error, W_stall = 0.
REQ-019 Read in same cycle as write to same address returns pre-write contents; new data is visible the following cycle.
REQ-020 W register update at rising clk, priority: W_stall = 1 holds all W fields; else W_bubble = 1 loads bubble; else loads normal.
REQ-021 Normal load: W_stat <= m_stat, W_icode <= M_icode, W_valE <= M_valE, W_valM <= m_valM, W_dstE <= M_dstE, W_dstM <= M_dstM.
REQ-022 Bubble value: W_stat 00, W_icode 1 (nop), W_valE 0, W_valM 0, W_dstE 0xF, W_dstM 0xF.
REQ-023 W_stall and W_bubble both 1: stall wins; W holds; no memory write (REQ-018).
REQ-024 Latency: m_* outputs 0 cycles from M inputs; W_* fields 1 cycle.

Reset
REQ-025 rst_n low asynchronously forces W fields to bubble value (REQ-022) regardless of clk; held while low.
REQ-026 No memory write occurs while rst_n low; memory contents are neither cleared nor altered by reset.
REQ-027 First rising clk after rst_n deasserts performs normal operation per REQ-018/REQ-020.

Verification
REQ-028 rmmovq (icode 4, valE 0x10, valA 0x1122334455667788, stat 00), then mrmovq valE 0x10 -> m_valM 0x1122334455667788, byte 0x10 = 0x88, W_valM matches one cycle later.
REQ-029 mrmovq with valE = MEM_BYTES-7 (1017) -> m_stat 10, m_valM 0, W_stat 10 next cycle; valE 1016 -> m_stat 00.
REQ-030 pushq (icode A, valE 0x100, valA 5) with M_stat 01 -> no write (later read of 0x100 unchanged); popq (icode B, valA 0x100) after a valid write returns written data.
REQ-031 W_stall = 1 with rmmovq to 0x20 -> W fields unchanged, memory 0x20 unchanged; W_bubble = 1 -> W_icode 1, W_dstE/W_dstM 0xF, W_stat 00.
REQ-032 rst_n pulled low mid-cycle while W holds icode 5 -> W_icode 1, W_dstM 0xF immediately without clk edge; memory retains prior data after release.
REQ-033 Same-cycle read and write at 0x40 (back-to-back pipeline) -> read returns old value that cycle, new value next cycle.
